// File: rtl/byte_bank_pkg.sv
// Shared definitions for the byte bank controller and its storage bank.
package byte_bank_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_STORE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_RD    = 3'd4,
    ST_ACK   = 3'd5
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_NSLOTS = 4;
  localparam int DEF_ADDR_W = 2;

endpackage

// File: rtl/byte_bank.sv
// Bank of byte_memory slots sharing one data bus, one store strobe per slot.
module byte_bank
  import byte_bank_pkg::*;
#(
  parameter int NSLOTS = DEF_NSLOTS
) (
  input  logic [7:0]          slot_data,
  input  logic [NSLOTS-1:0]   slot_store,
  output logic [8*NSLOTS-1:0] slot_q
);

  for (genvar i = 0; i < NSLOTS; i++) begin : g_slot
    byte_memory u_mem (
      .data   (slot_data),
      .store  (slot_store[i]),
      .memory (slot_q[8*i +: 8])
    );
  end

endmodule

// File: rtl/byte_memory.sv
// One byte of level-sensitive storage: transparent while store is high.
module byte_memory (
  input  logic [7:0] data,
  input  logic       store,
  output logic [7:0] memory
);

  // Transparent latch; the controller keeps data stable around every store pulse.
  always_latch begin
    if (store) memory <= data;
  end

endmodule

// File: rtl/byte_bank_ctrl.sv
// Two-requester sequencer for a latch-based byte bank.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | wait for a request, arbitrate, latch the granted fields
// SETUP    | write data on the bus, no strobe (data setup)
// STORE    | strobe of the addressed slot high for one cycle
// HOLD     | strobe low, data still held (data hold)
// RD       | capture the addressed slot into the requester's rdata
// ACK      | ack pulse visible, update round-robin pointer
module byte_bank_ctrl
  import byte_bank_pkg::*;
#(
  parameter int NSLOTS = DEF_NSLOTS,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                a_req,
  input  logic                a_we,
  input  logic [ADDR_W-1:0]   a_addr,
  input  logic [7:0]          a_wdata,
  output logic                a_ack,
  output logic [7:0]          a_rdata,
  input  logic                b_req,
  input  logic                b_we,
  input  logic [ADDR_W-1:0]   b_addr,
  input  logic [7:0]          b_wdata,
  output logic                b_ack,
  output logic [7:0]          b_rdata,
  output logic [7:0]          slot_data,
  output logic [NSLOTS-1:0]   slot_store,
  input  logic [8*NSLOTS-1:0] slot_q,
  output logic                busy
);

  state_t              state;
  logic                gnt;
  logic                last_grant;
  logic [ADDR_W-1:0]   l_addr;
  logic                pick;
  logic [NSLOTS-1:0]   store_vec;
  logic [7:0]          rd_byte;

  // Round-robin pick: B wins only when A is idle or A was served last.
  always_comb begin
    pick = REQ_A;
    if (b_req && (!a_req || last_grant == REQ_A)) pick = REQ_B;
  end

  // Address decode; an out-of-range address selects no slot and reads 0x00.
  always_comb begin
    store_vec = '0;
    rd_byte   = 8'h00;
    for (int i = 0; i < NSLOTS; i++) begin
      if (int'(l_addr) == i) begin
        store_vec[i] = 1'b1;
        rd_byte      = slot_q[8*i +: 8];
      end
    end
  end

  // Sequencer with registered outputs; slot_data is loaded only on IDLE->SETUP.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      gnt        <= REQ_A;
      last_grant <= REQ_B;
      l_addr     <= '0;
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      a_rdata    <= 8'h00;
      b_rdata    <= 8'h00;
      slot_data  <= 8'h00;
      slot_store <= '0;
      busy       <= 1'b0;
    end else begin
      a_ack      <= 1'b0;
      b_ack      <= 1'b0;
      slot_store <= '0;
      unique case (state)
        ST_IDLE: begin
          if (a_req || b_req) begin
            gnt  <= pick;
            busy <= 1'b1;
            if (pick == REQ_A) begin
              l_addr <= a_addr;
              if (a_we) begin
                slot_data <= a_wdata;
                state     <= ST_SETUP;
              end else begin
                state <= ST_RD;
              end
            end else begin
              l_addr <= b_addr;
              if (b_we) begin
                slot_data <= b_wdata;
                state     <= ST_SETUP;
              end else begin
                state <= ST_RD;
              end
            end
          end
        end
        ST_SETUP: begin
          slot_store <= store_vec;
          state      <= ST_STORE;
        end
        ST_STORE: begin
          state <= ST_HOLD;
        end
        ST_HOLD: begin
          a_ack <= (gnt == REQ_A);
          b_ack <= (gnt == REQ_B);
          state <= ST_ACK;
        end
        ST_RD: begin
          if (gnt == REQ_A) a_rdata <= rd_byte;
          else              b_rdata <= rd_byte;
          a_ack <= (gnt == REQ_A);
          b_ack <= (gnt == REQ_B);
          state <= ST_ACK;
        end
        ST_ACK: begin
          last_grant <= gnt;
          busy       <= 1'b0;
          state      <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_byte_bank_ctrl.sv
// Directed bench: a 4-slot controller+bank and a 3-slot controller+bank.
// Ports 0/1 = A/B of the 4-slot unit, port 2 = A of the 3-slot unit.
module tb_byte_bank_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req   [4];
  logic        we    [4];
  logic [1:0]  addr  [4];
  logic [7:0]  wdata [4];
  logic        ack   [4];
  logic [7:0]  rdata [4];

  logic [7:0]  sd4, sd3;
  logic [3:0]  st4;
  logic [2:0]  st3;
  logic [31:0] q4;
  logic [23:0] q3;
  logic        busy4, busy3;

  logic [7:0]  mem4 [4];
  logic [7:0]  mem3 [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  byte_bank_ctrl #(.NSLOTS(4), .ADDR_W(2)) u_ctrl4 (
    .clk(clk), .reset(reset),
    .a_req(req[0]), .a_we(we[0]), .a_addr(addr[0]), .a_wdata(wdata[0]),
    .a_ack(ack[0]), .a_rdata(rdata[0]),
    .b_req(req[1]), .b_we(we[1]), .b_addr(addr[1]), .b_wdata(wdata[1]),
    .b_ack(ack[1]), .b_rdata(rdata[1]),
    .slot_data(sd4), .slot_store(st4), .slot_q(q4), .busy(busy4)
  );

  byte_bank #(.NSLOTS(4)) u_bank4 (.slot_data(sd4), .slot_store(st4), .slot_q(q4));

  byte_bank_ctrl #(.NSLOTS(3), .ADDR_W(2)) u_ctrl3 (
    .clk(clk), .reset(reset),
    .a_req(req[2]), .a_we(we[2]), .a_addr(addr[2]), .a_wdata(wdata[2]),
    .a_ack(ack[2]), .a_rdata(rdata[2]),
    .b_req(req[3]), .b_we(we[3]), .b_addr(addr[3]), .b_wdata(wdata[3]),
    .b_ack(ack[3]), .b_rdata(rdata[3]),
    .slot_data(sd3), .slot_store(st3), .slot_q(q3), .busy(busy3)
  );

  byte_bank #(.NSLOTS(3)) u_bank3 (.slot_data(sd3), .slot_store(st3), .slot_q(q3));

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] sd_of(input int p);
    return (p < 2) ? sd4 : sd3;
  endfunction

  function automatic logic [3:0] st_of(input int p);
    return (p < 2) ? st4 : {1'b0, st3};
  endfunction

  function automatic logic busy_of(input int p);
    return (p < 2) ? busy4 : busy3;
  endfunction

  task automatic check_slots(input string tag);
    for (int i = 0; i < 4; i++) check_val($sformatf("%s_s4_%0d", tag, i), 32'(q4[8*i +: 8]), 32'(mem4[i]));
    for (int i = 0; i < 3; i++) check_val($sformatf("%s_s3_%0d", tag, i), 32'(q3[8*i +: 8]), 32'(mem3[i]));
  endtask

  // One transaction on port p, started at a negedge while the FSM is idle.
  task automatic xact(input int p, input logic w, input logic [1:0] ad, input logic [7:0] wd,
                      input logic [7:0] exp_rd, input logic [3:0] exp_st, input int exp_lat,
                      input string tag);
    logic [7:0] sd_h [4];
    logic [3:0] st_h [4];
    int n;
    logic got;
    we[p] = w; addr[p] = ad; wdata[p] = wd; req[p] = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (n < 4) begin
        sd_h[n] = sd_of(p);
        st_h[n] = st_of(p);
      end
      if (n == 1) check_val({tag, "_busy"}, 32'(busy_of(p)), 32'd1);
      got = ack[p];
    end
    req[p] = 1'b0;
    check_val({tag, "_ack"}, 32'(got), 32'd1);
    check_val({tag, "_lat"}, n, exp_lat);
    if (w) begin
      for (int i = 1; i < 4; i++) check_val($sformatf("%s_data%0d", tag, i), 32'(sd_h[i]), 32'(wd));
      check_val({tag, "_st_setup"}, 32'(st_h[1]), 32'd0);
      check_val({tag, "_st_store"}, 32'(st_h[2]), 32'(exp_st));
      check_val({tag, "_st_hold"},  32'(st_h[3]), 32'd0);
    end else begin
      check_val({tag, "_st_rd"}, 32'(st_h[1]), 32'd0);
      check_val({tag, "_rdata"}, 32'(rdata[p]), 32'(exp_rd));
    end
    @(negedge clk);
    check_val({tag, "_idle"}, 32'(busy_of(p)), 32'd0);
  endtask

  // Both requesters of the 4-slot unit write in the same cycle.
  task automatic tie(input logic [1:0] ad_a, input logic [7:0] wd_a,
                     input logic [1:0] ad_b, input logic [7:0] wd_b,
                     input int exp_a, input int exp_b, input string tag);
    int n, at_a, at_b;
    we[0] = 1'b1; addr[0] = ad_a; wdata[0] = wd_a; req[0] = 1'b1;
    we[1] = 1'b1; addr[1] = ad_b; wdata[1] = wd_b; req[1] = 1'b1;
    n = 0; at_a = 0; at_b = 0;
    while ((at_a == 0 || at_b == 0) && n < 30) begin
      @(negedge clk);
      n++;
      if (ack[0] && at_a == 0) begin at_a = n; req[0] = 1'b0; end
      if (ack[1] && at_b == 0) begin at_b = n; req[1] = 1'b0; end
    end
    req[0] = 1'b0; req[1] = 1'b0;
    check_val({tag, "_a_at"}, at_a, exp_a);
    check_val({tag, "_b_at"}, at_b, exp_b);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    int seen;
    for (int i = 0; i < 4; i++) begin
      req[i] = 1'b0; we[i] = 1'b0; addr[i] = 2'd0; wdata[i] = 8'h00;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);

    // Reset values
    check_val("rst_busy4", 32'(busy4), 32'd0);
    check_val("rst_busy3", 32'(busy3), 32'd0);
    check_val("rst_a_ack", 32'(ack[0]), 32'd0);
    check_val("rst_b_ack", 32'(ack[1]), 32'd0);
    check_val("rst_a_rdata", 32'(rdata[0]), 32'd0);
    check_val("rst_b_rdata", 32'(rdata[1]), 32'd0);
    check_val("rst_sd4", 32'(sd4), 32'd0);
    check_val("rst_st4", 32'(st4), 32'd0);
    check_val("rst_st3", 32'(st3), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Known contents in every slot
    for (int i = 0; i < 4; i++) begin
      mem4[i] = 8'h10 + 8'(i);
      xact(1, 1'b1, 2'(i), mem4[i], 8'h00, 4'(1 << i), 4, $sformatf("pre4_%0d", i));
    end
    for (int i = 0; i < 3; i++) begin
      mem3[i] = 8'h20 + 8'(i);
      xact(2, 1'b1, 2'(i), mem3[i], 8'h00, 4'(1 << i), 4, $sformatf("pre3_%0d", i));
    end
    check_slots("pre");

    // A writes 0xA5 to slot 2 and reads it back; B reads slot 3
    xact(0, 1'b1, 2'd2, 8'hA5, 8'h00, 4'b0100, 4, "a_wr2");
    mem4[2] = 8'hA5;
    check_slots("a_wr2");
    xact(0, 1'b0, 2'd2, 8'h00, 8'hA5, 4'b0000, 2, "a_rd2");
    xact(1, 1'b0, 2'd3, 8'h00, 8'h13, 4'b0000, 2, "b_rd3");

    // Tie: last grant was B, so A first, B five cycles later
    tie(2'd0, 8'h11, 2'd1, 8'h22, 4, 9, "tie1");
    mem4[0] = 8'h11; mem4[1] = 8'h22;
    check_slots("tie1");
    // A served alone, then a tie goes to B
    xact(0, 1'b0, 2'd2, 8'h00, 8'hA5, 4'b0000, 2, "a_rd2b");
    tie(2'd3, 8'h33, 2'd0, 8'h44, 9, 4, "tie2");
    mem4[3] = 8'h33; mem4[0] = 8'h44;
    check_slots("tie2");

    // Out-of-range slot on the 3-slot unit
    xact(2, 1'b1, 2'd3, 8'h5A, 8'h00, 4'b0000, 4, "oor_wr");
    check_slots("oor_wr");
    xact(2, 1'b0, 2'd1, 8'h00, 8'h21, 4'b0000, 2, "s3_rd1");
    xact(2, 1'b0, 2'd3, 8'h00, 8'h00, 4'b0000, 2, "oor_rd");

    // Reset while in STORE
    we[0] = 1'b1; addr[0] = 2'd1; wdata[0] = 8'h77; req[0] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_val("mid_in_store", 32'(st4), 32'b0010);
    reset = 1'b1;
    req[0] = 1'b0;
    @(negedge clk);
    check_val("mid_busy", 32'(busy4), 32'd0);
    check_val("mid_ack", 32'(ack[0]), 32'd0);
    check_val("mid_rdata", 32'(rdata[0]), 32'd0);
    check_val("mid_b_rdata", 32'(rdata[1]), 32'd0);
    check_val("mid_sd", 32'(sd4), 32'd0);
    check_val("mid_st", 32'(st4), 32'd0);
    reset = 1'b0;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack[0] || ack[1]) seen++;
    end
    check_val("mid_no_ack", seen, 0);
    xact(0, 1'b1, 2'd1, 8'h3C, 8'h00, 4'b0010, 4, "post_wr");
    mem4[1] = 8'h3C;
    check_slots("post");
    xact(0, 1'b0, 2'd1, 8'h00, 8'h3C, 4'b0000, 2, "post_rd");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/byte_bank_ctrl.md
# byte_bank_ctrl

Synchronous controller that sequences writes and reads into a bank of level-sensitive `byte_memory` latches and shares that bank between two requesters (A and B). It owns every latch `store` line, guaranteeing data is stable before and after each store pulse so no latch sees a data change while transparent. It sits between the processor-side requesters and the byte storage bank.

## Interface
- `NSLOTS`, default 4: number of byte_memory slots in the bank (2..16).
- `ADDR_W`, default 2: address width; must satisfy 2^ADDR_W >= NSLOTS.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `a_req`  in  1  requester A request; held high until `a_ack`.
- `a_we`  in  1  A: 1 = write, 0 = read.
- `a_addr`  in  ADDR_W  A slot address.
- `a_wdata`  in  8  A write data.
- `a_ack`  out  1  A completion pulse, one cycle.
- `a_rdata`  out  8  A read data, valid when `a_ack` is high and held until the next A read.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: same as A.
- `slot_data`  out  8  shared data bus to every slot's `data`.
- `slot_store`  out  NSLOTS  one-hot store strobe, bit i to slot i `store`.
- `slot_q`  in  8*NSLOTS  slot i `memory` output at bits [8i+7:8i].
- `busy`  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, SETUP, STORE, HOLD, RD, ACK.
- IDLE: if any `req` is high, grant one requester and latch its `we`, `addr`, `wdata` and identity into internal registers. Next state is SETUP for a write or RD for a read.
- Arbitration: round-robin via a `last_grant` register. On a tie, the requester not granted last wins. `last_grant` resets to B, so A wins the first tie. A single requester always wins.
- SETUP: drive `slot_data` = latched wdata; all `slot_store` are 0. Go to STORE.
- STORE: `slot_store[addr]` = 1, `slot_data` is unchanged. Go to HOLD.
- HOLD: all `slot_store` are 0, `slot_data` is still held. Go to ACK.
- RD: capture `slot_q[addr]` into the granted requester's `rdata` register. Go to ACK.
- ACK: pulse the granted requester's `ack` for one cycle, update `last_grant`, and go to IDLE.
- `slot_data` changes only in IDLE→SETUP transitions. It holds its last value at all other times, including in IDLE.
- Out-of-range address (addr >= NSLOTS):
  - Write: no `slot_store` bit asserts.
  - Read: `rdata` = 0x00.
  - Both are still acked with normal latency.
- Requester protocol:
  - `req`, `we`, `addr` and `wdata` must be stable from assertion until `ack`.
  - `req` must drop the cycle after `ack`, or be re-asserted for a new transaction from that cycle.
  - The controller samples request fields only in IDLE; later changes are ignored.

## Timing
- Reset values: `a_ack` = `b_ack` = 0, `a_rdata` = `b_rdata` = 0x00, `slot_data` = 0x00, `slot_store` = 0, `busy` = 0, FSM = IDLE.
- Write: `req` sampled in IDLE at edge 0. SETUP is cycle 1, STORE is cycle 2 (store high exactly one cycle), HOLD is cycle 3, and `ack` is high in cycle 4. Write latency is 4 cycles, with 1 cycle of data setup and 1 cycle of data hold around the strobe.
- Read: `req` sampled at edge 0. RD is cycle 1, and `ack` plus valid `rdata` are in cycle 2. Read latency is 2 cycles.
- Each transaction spends 1 cycle in IDLE between transactions. Back-to-back writes run every 5 cycles; back-to-back reads every 3.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- `slot_store` is never high for more than one consecutive cycle, and never high in the same cycle that `slot_data` changes.
- Reset mid-transaction:
  - At the reset edge, all outputs return to their reset values and `slot_store` deasserts.
  - No `ack` is issued for the aborted transaction.
  - Latch contents are untouched, apart from a store already completed.
- Both `req` arriving in the same IDLE cycle: one is granted; the other waits and is granted in the IDLE after the first `ack`.

## Structure
- Shared package `byte_bank_pkg` holds:
  - FSM state encodings (IDLE..ACK).
  - Requester ID constants `REQ_A` and `REQ_B`.
  - Default `NSLOTS` and `ADDR_W`.
- One natural sub-module, `byte_bank`: NSLOTS `byte_memory` instances sharing `slot_data`, with individual `slot_store` bits, flattening their outputs onto `slot_q`. `byte_bank_ctrl` stays storage-free apart from its registers.

## Test plan
- After reset, A writes 0xA5 to slot 2, then reads slot 2. Expect: `a_ack` 4 cycles after the write request, and `a_rdata` = 0xA5 with `a_ack` 2 cycles after the read request. Slots 0, 1 and 3 are unchanged.
- A and B both request writes in the same cycle (A: 0x11 to slot 0, B: 0x22 to slot 1). Expect: A acked first, B acked 5 cycles later, and both slots hold the correct values. Repeat the tie and expect B first.
- During a write, monitor the bus. Expect: `slot_data` stable from SETUP through HOLD, `slot_store` one-hot for exactly 1 cycle, and no other slot's value changing.
- With NSLOTS = 3, write to addr 3, then read addr 3. Expect: no store strobe, `rdata` = 0x00, and both transactions acked.
- Assert reset while the FSM is in STORE. Expect: all outputs return to their reset values at the reset edge, no `ack` is issued, and `busy` = 0. A subsequent write completes normally.
